dma_desc_sequencer: RTL and testbench

Top-level descriptor scheduler of the DMA. On a CSR "go" it walks the descriptor table in index order and, for every enabled, non-empty descriptor, launches the read and write streamers together. It then waits for both streamers to report done before moving on. It owns abort and error sequencing and produces the DMA-level active, done and status flags consumed by the CSR block.

---
 rtl/dma_desc_sequencer_if.sv | 23 ++
 rtl/dma_desc_sequencer.sv | 140 ++++++++++++++
 tb/tb_dma_desc_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_sequencer_if.sv
// rtl/dma_desc_sequencer_if.sv - read/write streamer launch and done handshake bundle
interface dma_desc_sequencer_if #(
   parameter int IDX_W = 1
);
   logic             rd_str_valid_o;
   logic [IDX_W-1:0] rd_str_idx_o;
   logic             rd_str_done_i;
   logic             wr_str_valid_o;
   logic [IDX_W-1:0] wr_str_idx_o;
   logic             wr_str_done_i;

   // sequencer side: launches both streamers and collects their done pulses
   modport master (
      output rd_str_valid_o, rd_str_idx_o, wr_str_valid_o, wr_str_idx_o,
      input  rd_str_done_i, wr_str_done_i
   );

   // streamer side
   modport slave (
      input  rd_str_valid_o, rd_str_idx_o, wr_str_valid_o, wr_str_idx_o,
      output rd_str_done_i, wr_str_done_i
   );
endinterface

// File: rtl/dma_desc_sequencer.sv
// rtl/dma_desc_sequencer.sv - DMA descriptor scheduler: scan, launch, wait, abort/error sequencing
module dma_desc_sequencer #(
   parameter int NUM_DESC = 2,
   parameter int IDX_W    = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dma_go_i,
   input  logic                dma_abort_i,
   input  logic [NUM_DESC-1:0] desc_en_i,
   input  logic [NUM_DESC-1:0] desc_nz_i,
   input  logic                dma_axi_err_i,
   dma_desc_sequencer_if.master str_if,
   output logic                dma_active_o,
   output logic                dma_done_o,
   output logic                dma_aborted_o,
   output logic                dma_error_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SCAN   = 3'd1;
   localparam logic [2:0] LAUNCH = 3'd2;
   localparam logic [2:0] WAIT   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DESC - 1);

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             aborted_q, aborted_d;
   logic             error_q, error_d;
   logic             rd_seen_q, rd_seen_d;
   logic             wr_seen_q, wr_seen_d;
   logic             last_idx;
   logic             slot_ready;

   assign last_idx   = (idx_q == LAST_IDX);
   assign slot_ready = desc_en_i[idx_q] & desc_nz_i[idx_q];

   // next-state decode: one slot per SCAN cycle, LAUNCH for a single cycle, WAIT for both dones
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      aborted_d = aborted_q;
      error_d   = error_q;
      rd_seen_d = rd_seen_q;
      wr_seen_d = wr_seen_q;
      // an AXI error is recorded in any active state and blocks later launches
      if (state_q != IDLE && dma_axi_err_i) begin
         error_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (dma_go_i) begin
               aborted_d = 1'b0;
               error_d   = 1'b0;
               idx_d     = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (dma_abort_i) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (error_d) begin
               state_d = DONE;
            end else if (slot_ready) begin
               state_d = LAUNCH;
            end else if (last_idx) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         LAUNCH: begin
            if (dma_abort_i) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else begin
               rd_seen_d = 1'b0;
               wr_seen_d = 1'b0;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // abort is only recorded here; the streamers still owe their done pulses
            if (dma_abort_i) begin
               aborted_d = 1'b1;
            end
            rd_seen_d = rd_seen_q | str_if.rd_str_done_i;
            wr_seen_d = wr_seen_q | str_if.wr_str_done_i;
            if (rd_seen_d && wr_seen_d) begin
               if (aborted_d || error_d || last_idx) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SCAN;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, index and sticky status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         aborted_q <= 1'b0;
         error_q   <= 1'b0;
         rd_seen_q <= 1'b0;
         wr_seen_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         aborted_q <= aborted_d;
         error_q   <= error_d;
         rd_seen_q <= rd_seen_d;
         wr_seen_q <= wr_seen_d;
      end
   end

   // launch strobes come straight off the LAUNCH state register; a same-cycle abort suppresses them
   assign str_if.rd_str_valid_o = (state_q == LAUNCH) && !dma_abort_i;
   assign str_if.wr_str_valid_o = (state_q == LAUNCH) && !dma_abort_i;
   assign str_if.rd_str_idx_o   = idx_q;
   assign str_if.wr_str_idx_o   = idx_q;

   assign dma_active_o  = (state_q != IDLE);
   assign dma_done_o    = (state_q == DONE);
   assign dma_aborted_o = aborted_q;
   assign dma_error_o   = error_q;

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// tb/tb_dma_desc_sequencer.sv - directed scoreboard bench for dma_desc_sequencer
module tb_dma_desc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       dma_go_i = 1'b0;
   logic       dma_abort_i = 1'b0;
   logic [1:0] desc_en_i = 2'b00;
   logic [1:0] desc_nz_i = 2'b00;
   logic       dma_axi_err_i = 1'b0;
   logic       dma_active_o, dma_done_o, dma_aborted_o, dma_error_o;

   int errors = 0;
   int checks = 0;
   int launches = 0;
   int done_cnt = 0;
   int exp_q[$];
   int lat;

   dma_desc_sequencer_if #(.IDX_W(1)) sif ();

   dma_desc_sequencer #(.NUM_DESC(2), .IDX_W(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .dma_go_i      (dma_go_i),
      .dma_abort_i   (dma_abort_i),
      .desc_en_i     (desc_en_i),
      .desc_nz_i     (desc_nz_i),
      .dma_axi_err_i (dma_axi_err_i),
      .str_if        (sif.master),
      .dma_active_o  (dma_active_o),
      .dma_done_o    (dma_done_o),
      .dma_aborted_o (dma_aborted_o),
      .dma_error_o   (dma_error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_pulse();
      dma_go_i = 1'b1;
      step();
      dma_go_i = 1'b0;
   endtask

   task automatic pulse_done();
      sif.rd_str_done_i = 1'b1;
      sif.wr_str_done_i = 1'b1;
      step();
      sif.rd_str_done_i = 1'b0;
      sif.wr_str_done_i = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int l);
      l = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (sif.rd_str_valid_o) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic wait_done(input int bound, output int l);
      l = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (dma_done_o) begin
            l = i;
            break;
         end
      end
   endtask

   // launch monitor: every valid must match the next expected index and both streamers fire together
   always @(negedge clk) begin
      if (rst) begin
         if (sif.rd_str_valid_o || sif.wr_str_valid_o) begin
            launches++;
            chk("valid_pair", {31'd0, sif.wr_str_valid_o}, {31'd0, sif.rd_str_valid_o});
            if (exp_q.size() == 0) begin
               chk("unexpected_launch", 32'd1, 32'd0);
            end else begin
               int e;
               e = exp_q.pop_front();
               chk("rd_idx", {31'd0, sif.rd_str_idx_o}, 32'(e));
               chk("wr_idx", {31'd0, sif.wr_str_idx_o}, 32'(e));
            end
         end
         if (dma_done_o) done_cnt++;
      end
   end

   initial begin
      sif.rd_str_done_i = 1'b0;
      sif.wr_str_done_i = 1'b0;
      // reset state
      #12;
      chk("rst_active", {31'd0, dma_active_o}, 32'd0);
      chk("rst_done", {31'd0, dma_done_o}, 32'd0);
      chk("rst_valid", {31'd0, sif.rd_str_valid_o}, 32'd0);
      step();
      rst = 1'b1;
      step();

      // full table, dones 10 cycles after each launch
      desc_en_i = 2'b11;
      desc_nz_i = 2'b11;
      exp_q.push_back(0);
      exp_q.push_back(1);
      go_pulse();
      wait_valid(20, lat);
      chk("t1_first_launch_lat", 32'(lat), 32'd1);
      repeat (10) step();
      pulse_done();
      wait_valid(20, lat);
      chk("t1_next_launch_gap", 32'(lat), 32'd1);
      repeat (10) step();
      pulse_done();
      wait_done(20, lat);
      chk("t1_done_lat", 32'(lat), 32'd0);
      chk("t1_active_in_done", {31'd0, dma_active_o}, 32'd1);
      chk("t1_aborted", {31'd0, dma_aborted_o}, 32'd0);
      chk("t1_error", {31'd0, dma_error_o}, 32'd0);
      step();
      @(negedge clk);
      chk("t1_idle_active", {31'd0, dma_active_o}, 32'd0);
      chk("t1_idle_done", {31'd0, dma_done_o}, 32'd0);
      chk("t1_launches", 32'(launches), 32'd2);
      step();

      // slot 0 disabled: single launch for idx 1 in cycle 3
      desc_en_i = 2'b10;
      exp_q.push_back(1);
      go_pulse();
      wait_valid(20, lat);
      chk("t2_launch_lat", 32'(lat), 32'd2);
      step();
      pulse_done();
      wait_done(20, lat);
      chk("t2_done_lat", 32'(lat), 32'd0);
      step();
      chk("t2_launches", 32'(launches), 32'd3);

      // fully disabled table: done in cycle 3, no launches
      desc_en_i = 2'b00;
      go_pulse();
      wait_done(20, lat);
      chk("t3_done_lat", 32'(lat), 32'd2);
      step();
      chk("t3_launches", 32'(launches), 32'd3);

      // abort in WAIT on idx 0, rd done 2 cycles before wr done
      desc_en_i = 2'b11;
      exp_q.push_back(0);
      go_pulse();
      wait_valid(20, lat);
      chk("t4_launch_lat", 32'(lat), 32'd1);
      step();
      dma_abort_i = 1'b1;
      step();
      step();
      sif.rd_str_done_i = 1'b1;
      step();
      sif.rd_str_done_i = 1'b0;
      @(negedge clk);
      chk("t4_no_done_after_rd", {31'd0, dma_done_o}, 32'd0);
      chk("t4_aborted_in_wait", {31'd0, dma_aborted_o}, 32'd1);
      step();
      sif.wr_str_done_i = 1'b1;
      @(negedge clk);
      chk("t4_no_done_same_cycle", {31'd0, dma_done_o}, 32'd0);
      step();
      sif.wr_str_done_i = 1'b0;
      dma_abort_i = 1'b0;
      @(negedge clk);
      chk("t4_done_after_wr", {31'd0, dma_done_o}, 32'd1);
      chk("t4_aborted", {31'd0, dma_aborted_o}, 32'd1);
      repeat (4) step();
      chk("t4_launches", 32'(launches), 32'd4);

      // AXI error in WAIT on idx 0: idx 1 never launched
      exp_q.push_back(0);
      go_pulse();
      wait_valid(20, lat);
      chk("t5_launch_lat", 32'(lat), 32'd1);
      chk("t5_aborted_cleared", {31'd0, dma_aborted_o}, 32'd0);
      step();
      dma_axi_err_i = 1'b1;
      step();
      dma_axi_err_i = 1'b0;
      step();
      pulse_done();
      wait_done(20, lat);
      chk("t5_done_lat", 32'(lat), 32'd0);
      chk("t5_error", {31'd0, dma_error_o}, 32'd1);
      repeat (4) step();
      chk("t5_launches", 32'(launches), 32'd5);
      chk("t5_error_sticky", {31'd0, dma_error_o}, 32'd1);
      desc_en_i = 2'b00;
      go_pulse();
      @(negedge clk);
      chk("t5_error_cleared", {31'd0, dma_error_o}, 32'd0);
      wait_done(20, lat);
      chk("t5b_done_seen", {31'd0, dma_done_o}, 32'd1);
      step();
      step();

      // go while active is ignored; reset mid-WAIT clears everything at once
      desc_en_i = 2'b11;
      exp_q.push_back(0);
      go_pulse();
      wait_valid(20, lat);
      chk("t6_launch_lat", 32'(lat), 32'd1);
      step();
      dma_go_i = 1'b1;
      dma_axi_err_i = 1'b1;
      step();
      dma_go_i = 1'b0;
      dma_axi_err_i = 1'b0;
      @(negedge clk);
      chk("t6_still_active", {31'd0, dma_active_o}, 32'd1);
      chk("t6_error_kept", {31'd0, dma_error_o}, 32'd1);
      step();
      rst = 1'b0;
      #1;
      chk("t6_rst_active", {31'd0, dma_active_o}, 32'd0);
      chk("t6_rst_error", {31'd0, dma_error_o}, 32'd0);
      chk("t6_rst_aborted", {31'd0, dma_aborted_o}, 32'd0);
      chk("t6_rst_idx", {31'd0, sif.rd_str_idx_o}, 32'd0);
      step();
      rst = 1'b1;
      pulse_done();
      repeat (3) begin
         @(negedge clk);
         chk("t6_late_done_active", {31'd0, dma_active_o}, 32'd0);
      end
      chk("t6_launches", 32'(launches), 32'd6);
      chk("done_count", 32'(done_cnt), 32'd6);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
